// File: rtl/div_pkg.sv
// Shared types and helpers for the divider arbiter.
// State encoding, operand width and the request reject rule.
package div_pkg;

   localparam int W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      RESP = 2'd3
   } state_t;

   // A zero divisor, or a negative divisor in signed mode, cannot be served.
   function automatic logic reject(input logic [W-1:0] y,
                                   input logic         sgn);
      return (y == '0) || (sgn && y[W-1]);
   endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Client-side request/response bundle of the divider arbiter.
// master = requesters, slave = arbiter.
interface div_arbiter_if
   import div_pkg::*;
#(
   parameter int N = 2
);

   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_x;
   logic [N*W-1:0] req_y;
   logic [N-1:0]   req_signed;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_quot;
   logic [W-1:0]   rsp_rem;
   logic           rsp_err;

   modport master (
      output req_valid, req_x, req_y, req_signed,
      input  req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err
   );

   modport slave (
      input  req_valid, req_x, req_y, req_signed,
      output req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err
   );

endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker: first valid after ptr, wrapping.
// Purely combinational; grant is one-hot or zero.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   logic found;
   int   j;

   // Scan N slots starting just past the last winner.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && valid[j[PW-1:0]]) begin
            found              = 1'b1;
            grant[j[PW-1:0]]   = 1'b1;
            idx                = j[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative 32-bit divider among N requesters.
// Round-robin grant, floor-signed correction, early reject.
module div_arbiter
   import div_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   div_arbiter_if.slave bus,
   output logic         div_run,
   output logic [W-1:0] div_x,
   output logic [W-1:0] div_y,
   input  logic         div_stall,
   input  logic [W-1:0] div_quot,
   input  logic [W-1:0] div_rem
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   state_t         state, nxt;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  owner;
   logic [N-1:0]   grant;
   logic [PW-1:0]  gidx;
   logic [W-1:0]   sel_x, sel_y;
   logic           sel_s;
   logic           rej;
   logic           xneg;
   logic [W-1:0]   qp, rp;
   logic [W-1:0]   fq, fr;
   logic [W-1:0]   quot_q, rem_q;
   logic           err_q;
   logic           take;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx)
   );

   // Operands of the candidate winner.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            sel_x = bus.req_x[i*W +: W];
            sel_y = bus.req_y[i*W +: W];
            sel_s = bus.req_signed[i];
         end
      end
   end

   assign rej  = reject(sel_y, sel_s);
   assign take = (state == IDLE) && (|grant);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Next state and handshake/strobe outputs.
   always_comb begin
      nxt           = state;
      div_run       = 1'b0;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      unique case (state)
         IDLE: begin
            bus.req_ready = rst ? grant : '0;
            if (|grant) nxt = rej ? RESP : RUN;
         end
         RUN: begin
            div_run = 1'b1;
            if (!div_stall) nxt = FIX;
         end
         FIX: nxt = RESP;
         RESP: begin
            bus.rsp_valid[owner] = 1'b1;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Floor correction of the magnitude result for negative dividends.
   always_comb begin
      fq = qp;
      fr = rp;
      if (xneg) begin
         if (rp == '0) begin
            fq = -qp;
         end else begin
            fq = ~qp;
            fr = div_y - rp;
         end
      end
   end

   // Operand latch, raw result capture and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr    <= PW'(N - 1);
         owner  <= '0;
         xneg   <= 1'b0;
         div_x  <= '0;
         div_y  <= '0;
         qp     <= '0;
         rp     <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (take) begin
            owner <= gidx;
            ptr   <= gidx;
            xneg  <= sel_s & sel_x[W-1];
            if (rej) begin
               err_q  <= 1'b1;
               quot_q <= '0;
               rem_q  <= sel_x;
            end else begin
               err_q <= 1'b0;
               div_x <= (sel_s & sel_x[W-1]) ? -sel_x : sel_x;
               div_y <= sel_y;
            end
         end
         if (state == RUN && !div_stall) begin
            qp <= div_quot;
            rp <= div_rem;
         end
         if (state == FIX) begin
            quot_q <= fq;
            rem_q  <= fr;
         end
      end
   end

   assign bus.rsp_quot = quot_q;
   assign bus.rsp_rem  = rem_q;
   assign bus.rsp_err  = err_q;

endmodule
